// File: rtl/mem_io_ctrl.sv
// Memory/IO controller behind the CPU core: 512x16 RAM, an LED register and a
// synchronised switch input, with a configurable number of wait states per access.
module mem_io_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [8:0]  LED_ADDR    = 9'h100,
    parameter logic [8:0]  SW_ADDR     = 9'h140
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  mem_addr,
    input  logic [1:0]  m_cmd,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [9:0]  leds,
    input  logic [9:0]  sw,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  addr_q;
    cmd_e        cmd_q;
    logic [15:0] wdata_q;
    logic [15:0] read_data_q;
    logic [9:0]  leds_q;
    logic [9:0]  sw_meta_q, sw_sync_q;
    logic [15:0] ram_q [512];

    logic        capture;
    logic        rd_load;
    logic [8:0]  acc_addr;
    cmd_e        acc_cmd;
    logic [15:0] rd_mux;
    logic        ram_we;
    logic        led_we;

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        acc_addr = addr_q;
        acc_cmd  = cmd_q;
        unique case (state_q)
            ST_IDLE: begin
                acc_addr = mem_addr;
                acc_cmd  = cmd_e'(m_cmd);
                if (acc_cmd == CMD_READ || acc_cmd == CMD_WRITE) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is loaded on the edge that enters DONE so it is valid alongside mem_ready.
    assign rd_load = (state_d == ST_DONE) && (state_q != ST_DONE) && (acc_cmd == CMD_READ);

    always_comb begin
        rd_mux = ram_q[acc_addr];
        if (acc_addr == LED_ADDR) begin
            rd_mux = {6'b0, leds_q};
        end else if (acc_addr == SW_ADDR) begin
            rd_mux = {6'b0, sw_sync_q};
        end
    end

    assign led_we = (state_q == ST_DONE) && (cmd_q == CMD_WRITE) && (addr_q == LED_ADDR);
    assign ram_we = (state_q == ST_DONE) && (cmd_q == CMD_WRITE) && reset &&
                    (addr_q != LED_ADDR) && (addr_q != SW_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 9'd0;
            cmd_q       <= CMD_NONE;
            wdata_q     <= 16'h0000;
            read_data_q <= 16'h0000;
            leds_q      <= 10'h000;
            sw_meta_q   <= 10'h000;
            sw_sync_q   <= 10'h000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            if (capture) begin
                addr_q  <= mem_addr;
                cmd_q   <= cmd_e'(m_cmd);
                wdata_q <= write_data;
            end
            if (rd_load) begin
                read_data_q <= rd_mux;
            end
            if (led_we) begin
                leds_q <= wdata_q[9:0];
            end
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and the array
    // can map onto block memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[addr_q] <= wdata_q;
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign leds      = leds_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: one instance with no wait states and one
// with three, driven through a shared access task.
module tb_mem_io_ctrl;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic [8:0]  addr     [2];
    logic [1:0]  m_cmd    [2];
    logic [15:0] wdata    [2];
    logic [15:0] rdata    [2];
    logic        ready    [2];
    logic [9:0]  leds     [2];
    logic        busy     [2];
    logic [9:0]  sw;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] model_ram  [2][512];
    logic [9:0]  model_leds [2];
    logic [15:0] last_read  [2];
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    mem_io_ctrl #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[0]), .mem_addr(addr[0]), .m_cmd(m_cmd[0]),
        .write_data(wdata[0]), .read_data(rdata[0]), .mem_ready(ready[0]),
        .leds(leds[0]), .sw(sw), .busy(busy[0])
    );

    mem_io_ctrl #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst[1]), .mem_addr(addr[1]), .m_cmd(m_cmd[1]),
        .write_data(wdata[1]), .read_data(rdata[1]), .mem_ready(ready[1]),
        .leds(leds[1]), .sw(sw), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int d, input logic [8:0] a);
        if (a == LED_ADDR) return {6'b0, model_leds[d]};
        if (a == SW_ADDR)  return {6'b0, sw};
        return model_ram[d][a];
    endfunction

    // One complete access; address and data are scrambled right after capture.
    task automatic access(input int d, input logic [1:0] cmd, input logic [8:0] a,
                          input logic [15:0] wd, input int lat);
        int n;
        int busy_n;
        logic [15:0] exp_rd;
        @(negedge clk);
        m_cmd[d] = cmd;
        addr[d]  = a;
        wdata[d] = wd;
        if (cmd == 2'b01) sb.push_back(model_read(d, a));
        @(posedge clk);
        #1;
        m_cmd[d] = 2'b00;
        addr[d]  = 9'($urandom);
        wdata[d] = 16'($urandom);
        n = 1;
        busy_n = 0;
        while (n <= 40) begin
            if (busy[d]) busy_n++;
            if (ready[d]) break;
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency d%0d a%h", d, a), n, lat);
        check($sformatf("busy_len d%0d a%h", d, a), busy_n, lat);
        if (cmd == 2'b01) begin
            exp_rd = sb.pop_front();
            check($sformatf("rdata d%0d a%h", d, a), {16'h0, rdata[d]}, {16'h0, exp_rd});
            last_read[d] = exp_rd;
        end else begin
            check($sformatf("rdata_hold d%0d", d), {16'h0, rdata[d]}, {16'h0, last_read[d]});
            if (a == LED_ADDR) model_leds[d] = wd[9:0];
            else if (a != SW_ADDR) model_ram[d][a] = wd;
        end
        @(posedge clk);
        #1;
        check($sformatf("pulse d%0d", d), {31'h0, ready[d]}, 32'h0);
        check($sformatf("idle d%0d", d), {31'h0, busy[d]}, 32'h0);
        check($sformatf("leds d%0d", d), {22'h0, leds[d]}, {22'h0, model_leds[d]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  pattern;
        logic        seen;
        logic [8:0]  ra;
        logic [15:0] rd;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; addr[d] = '0; m_cmd[d] = 2'b00; wdata[d] = '0;
            model_leds[d] = '0; last_read[d] = '0;
        end
        sw = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_leds d%0d", d), {22'h0, leds[d]}, 32'h0);
            check($sformatf("rst_rdata d%0d", d), {16'h0, rdata[d]}, 32'h0);
            check($sformatf("rst_ready d%0d", d), {31'h0, ready[d]}, 32'h0);
            check($sformatf("rst_busy d%0d", d), {31'h0, busy[d]}, 32'h0);
        end

        // Basic RAM write/read on both wait-state settings.
        access(0, 2'b10, 9'h005, 16'hBEEF, 1);
        access(0, 2'b01, 9'h005, 16'h0000, 1);
        access(1, 2'b10, 9'h1FF, 16'h1234, 4);
        access(1, 2'b01, 9'h1FF, 16'h0000, 4);
        access(1, 2'b10, 9'h0AB, 16'hC0DE, 4);
        access(1, 2'b01, 9'h0AB, 16'h0000, 4);

        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 2; d++) begin
                ra = 9'($urandom);
                if (ra == LED_ADDR || ra == SW_ADDR) ra = ra + 9'd1;
                rd = 16'($urandom);
                access(d, 2'b10, ra, rd, d ? 4 : 1);
                access(d, 2'b01, ra, 16'h0000, d ? 4 : 1);
            end
        end

        // LED register and switch input.
        access(0, 2'b10, LED_ADDR, 16'hFFFF, 1);
        access(0, 2'b01, LED_ADDR, 16'h0000, 1);
        #3 sw = 10'h2A5;
        repeat (3) @(posedge clk);
        access(0, 2'b01, SW_ADDR, 16'h0000, 1);
        access(1, 2'b01, SW_ADDR, 16'h0000, 4);
        access(0, 2'b10, SW_ADDR, 16'h0000, 1);
        access(0, 2'b01, 9'h005, 16'h0000, 1);

        // Command held across DONE issues a second write.
        @(negedge clk);
        m_cmd[0] = 2'b10; addr[0] = 9'h030; wdata[0] = 16'h1111;
        pattern = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            pattern = {pattern[3:0], ready[0]};
            if (k == 2) m_cmd[0] = 2'b00;
        end
        check("held_cmd_pulses", {27'h0, pattern}, {27'h0, 5'b10100});
        model_ram[0][9'h030] = 16'h1111;
        access(0, 2'b01, 9'h030, 16'h0000, 1);

        // Reserved command does nothing.
        @(negedge clk);
        m_cmd[0] = 2'b11;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            seen = seen | busy[0] | ready[0];
        end
        m_cmd[0] = 2'b00;
        check("rsvd_cmd_idle", {31'h0, seen}, 32'h0);

        // Reset during WAIT aborts the write.
        access(1, 2'b10, 9'h020, 16'hAAAA, 4);
        access(1, 2'b10, LED_ADDR, 16'h0155, 4);
        @(negedge clk);
        m_cmd[1] = 2'b10; addr[1] = 9'h020; wdata[1] = 16'h5555;
        @(posedge clk);
        #1;
        m_cmd[1] = 2'b00;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            seen = seen | ready[1] | busy[1];
        end
        check("abort_no_ready", {31'h0, seen}, 32'h0);
        model_leds[1] = '0;
        last_read[1]  = '0;
        check("abort_rdata", {16'h0, rdata[1]}, 32'h0);
        check("abort_leds", {22'h0, leds[1]}, 32'h0);
        access(1, 2'b01, 9'h020, 16'h0000, 4);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
